// File: rtl/hazard_pipe_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cpu_defs : RegDst codes, hazard-bundle field widths, control FSM encoding
// Rev 1.0
// ---------------------------------------------------------------------------
package cpu_defs;
    localparam int REGDST_W = 2;
    localparam int CMP_W    = 2;
    localparam int CNT_W    = 2;

    localparam logic [REGDST_W-1:0] REGDST_ALU  = 2'b00;
    localparam logic [REGDST_W-1:0] REGDST_LOAD = 2'b01;
    localparam logic [REGDST_W-1:0] REGDST_PC4  = 2'b10;
    localparam logic [REGDST_W-1:0] REGDST_CMP  = 2'b11;

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_LSTALL = 1'b1;
endpackage
`default_nettype wire

// File: rtl/hazard_pipe_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hazard_pipe_ctrl_if : EX/ID inputs, pre/ppre bundles and pipeline controls
// Rev 1.0
// ---------------------------------------------------------------------------
interface hazard_pipe_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    import cpu_defs::*;

    logic                exValid;
    logic                exRegWr;
    logic [REGDST_W-1:0] exRegDst;
    logic [REG_W-1:0]    exrd;
    logic [CMP_W-1:0]    excmp;
    logic [DATA_W-1:0]   exAluOutput;
    logic [DATA_W-1:0]   memDataOut;
    logic                exBranchTaken;
    logic                idValid;
    logic [REG_W-1:0]    idrs1;
    logic [REG_W-1:0]    idrs2;
    logic                idUsesRs1;
    logic                idUsesRs2;

    logic                preMwk;
    logic                preRegWr;
    logic [REGDST_W-1:0] preRegDst;
    logic [REG_W-1:0]    prerd;
    logic [CMP_W-1:0]    precmp;
    logic [DATA_W-1:0]   preAluOutput;
    logic                ppreMwk;
    logic                ppreRegWr;
    logic [REGDST_W-1:0] ppreRegDst;
    logic [REG_W-1:0]    pprerd;
    logic [CMP_W-1:0]    pprecmp;
    logic [DATA_W-1:0]   ppreAluOutput;
    logic [DATA_W-1:0]   ppreDataOut;
    logic                stall;
    logic                bubble;
    logic                flush;

    modport master (
        output exValid, exRegWr, exRegDst, exrd, excmp, exAluOutput, memDataOut,
               exBranchTaken, idValid, idrs1, idrs2, idUsesRs1, idUsesRs2,
        input  preMwk, preRegWr, preRegDst, prerd, precmp, preAluOutput,
               ppreMwk, ppreRegWr, ppreRegDst, pprerd, pprecmp, ppreAluOutput,
               ppreDataOut, stall, bubble, flush
    );

    modport slave (
        input  exValid, exRegWr, exRegDst, exrd, excmp, exAluOutput, memDataOut,
               exBranchTaken, idValid, idrs1, idrs2, idUsesRs1, idUsesRs2,
        output preMwk, preRegWr, preRegDst, prerd, precmp, preAluOutput,
               ppreMwk, ppreRegWr, ppreRegDst, pprerd, pprecmp, ppreAluOutput,
               ppreDataOut, stall, bubble, flush
    );
endinterface
`default_nettype wire

// File: rtl/hazard_pipe_ctrl_bundle_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hazard_bundle_reg : one stage of hazard-bundle registers with Mwk masking
// Rev 1.0
// ---------------------------------------------------------------------------
module hazard_bundle_reg
    import cpu_defs::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                d_valid,
    input  wire logic                d_reg_wr,
    input  wire logic [REGDST_W-1:0] d_reg_dst,
    input  wire logic [REG_W-1:0]    d_rd,
    input  wire logic [CMP_W-1:0]    d_cmp,
    input  wire logic [DATA_W-1:0]   d_alu,
    output logic                     q_mwk,
    output logic                     q_reg_wr,
    output logic [REGDST_W-1:0]      q_reg_dst,
    output logic [REG_W-1:0]         q_rd,
    output logic [CMP_W-1:0]         q_cmp,
    output logic [DATA_W-1:0]        q_alu
);
    // Consumers never test for x0, so a write to x0 must not look valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_mwk     <= 1'b0;
            q_reg_wr  <= 1'b0;
            q_reg_dst <= '0;
            q_rd      <= '0;
            q_cmp     <= '0;
            q_alu     <= '0;
        end else begin
            q_mwk     <= d_valid & d_reg_wr & (d_rd != '0);
            q_reg_wr  <= d_reg_wr;
            q_reg_dst <= d_reg_dst;
            q_rd      <= d_rd;
            q_cmp     <= d_cmp;
            q_alu     <= d_alu;
        end
    end
endmodule
`default_nettype wire

// File: rtl/hazard_pipe_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hazard_pipe_ctrl : pre/ppre bundle producer, load-use detect, stall/flush
// Rev 1.0
// ---------------------------------------------------------------------------
module hazard_pipe_ctrl
    import cpu_defs::*;
#(
    parameter int DATA_W            = 32,
    parameter int REG_W             = 5,
    parameter int LOAD_STALL_CYCLES = 1
) (
    input  wire logic         CLK,
    input  wire logic         Reset,
    hazard_pipe_ctrl_if.slave bus
);
    localparam logic [CNT_W-1:0] c_CNT_INIT =
        CNT_W'((LOAD_STALL_CYCLES > 1) ? (LOAD_STALL_CYCLES - 2) : 0);

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_hz;
    logic             w_stall;
    logic             w_bubble;
    logic             w_flush;

    hazard_bundle_reg #(.DATA_W(DATA_W), .REG_W(REG_W)) u_pre (
        .clk       (CLK),
        .rst       (Reset),
        .d_valid   (bus.exValid),
        .d_reg_wr  (bus.exRegWr),
        .d_reg_dst (bus.exRegDst),
        .d_rd      (bus.exrd),
        .d_cmp     (bus.excmp),
        .d_alu     (bus.exAluOutput),
        .q_mwk     (bus.preMwk),
        .q_reg_wr  (bus.preRegWr),
        .q_reg_dst (bus.preRegDst),
        .q_rd      (bus.prerd),
        .q_cmp     (bus.precmp),
        .q_alu     (bus.preAluOutput)
    );

    hazard_bundle_reg #(.DATA_W(DATA_W), .REG_W(REG_W)) u_ppre (
        .clk       (CLK),
        .rst       (Reset),
        .d_valid   (bus.preMwk),
        .d_reg_wr  (bus.preRegWr),
        .d_reg_dst (bus.preRegDst),
        .d_rd      (bus.prerd),
        .d_cmp     (bus.precmp),
        .d_alu     (bus.preAluOutput),
        .q_mwk     (bus.ppreMwk),
        .q_reg_wr  (bus.ppreRegWr),
        .q_reg_dst (bus.ppreRegDst),
        .q_rd      (bus.pprerd),
        .q_cmp     (bus.pprecmp),
        .q_alu     (bus.ppreAluOutput)
    );

    always_ff @(posedge CLK) begin
        if (Reset) bus.ppreDataOut <= '0;
        else       bus.ppreDataOut <= bus.memDataOut;
    end

    // Only a load in EX is too late for forwarding; x0 is never a dependency.
    assign w_hz = bus.idValid & bus.exValid & bus.exRegWr
                & (bus.exRegDst == REGDST_LOAD) & (bus.exrd != '0)
                & ((bus.idUsesRs1 & (bus.idrs1 == bus.exrd))
                 | (bus.idUsesRs2 & (bus.idrs2 == bus.exrd)));

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_RUN: begin
                if (!bus.exBranchTaken && w_hz && (LOAD_STALL_CYCLES > 1)) begin
                    w_state_nxt = ST_LSTALL;
                    w_cnt_nxt   = c_CNT_INIT;
                end
            end
            ST_LSTALL: begin
                if (r_cnt == '0) w_state_nxt = ST_RUN;
                else             w_cnt_nxt   = r_cnt - 1'b1;
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // A taken branch beats the hazard: the ID instruction is wrong-path anyway.
    always_comb begin
        w_stall  = 1'b0;
        w_bubble = 1'b0;
        w_flush  = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (bus.exBranchTaken) begin
                    w_flush  = 1'b1;
                    w_bubble = 1'b1;
                end else if (w_hz) begin
                    w_stall  = 1'b1;
                    w_bubble = 1'b1;
                end
            end
            ST_LSTALL: begin
                w_stall  = 1'b1;
                w_bubble = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.stall  = w_stall;
    assign bus.bubble = w_bubble;
    assign bus.flush  = w_flush;
endmodule
`default_nettype wire

// File: tb/tb_hazard_pipe_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_hazard_pipe_ctrl : directed checks on 1-cycle and 3-cycle stall variants
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_hazard_pipe_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fails  = 0;

    always #5 clk = ~clk;

    hazard_pipe_ctrl_if #(.DATA_W(32), .REG_W(5)) b1 ();
    hazard_pipe_ctrl_if #(.DATA_W(32), .REG_W(5)) b3 ();

    hazard_pipe_ctrl #(.DATA_W(32), .REG_W(5), .LOAD_STALL_CYCLES(1)) u_dut1 (
        .CLK(clk), .Reset(rst), .bus(b1));
    hazard_pipe_ctrl #(.DATA_W(32), .REG_W(5), .LOAD_STALL_CYCLES(3)) u_dut3 (
        .CLK(clk), .Reset(rst), .bus(b3));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle1();
        b1.exValid = 0; b1.exRegWr = 0; b1.exRegDst = 2'b00; b1.exrd = 0;
        b1.excmp = 0; b1.exAluOutput = 0; b1.memDataOut = 0; b1.exBranchTaken = 0;
        b1.idValid = 0; b1.idrs1 = 0; b1.idrs2 = 0; b1.idUsesRs1 = 0; b1.idUsesRs2 = 0;
    endtask

    task automatic idle3();
        b3.exValid = 0; b3.exRegWr = 0; b3.exRegDst = 2'b00; b3.exrd = 0;
        b3.excmp = 0; b3.exAluOutput = 0; b3.memDataOut = 0; b3.exBranchTaken = 0;
        b3.idValid = 0; b3.idrs1 = 0; b3.idrs2 = 0; b3.idUsesRs1 = 0; b3.idUsesRs2 = 0;
    endtask

    // Load in EX writing rd, ID reading rs1 of the same register
    task automatic load3(input logic [4:0] rd);
        b3.exValid = 1; b3.exRegWr = 1; b3.exRegDst = 2'b01; b3.exrd = rd;
        b3.idValid = 1; b3.idUsesRs1 = 1; b3.idrs1 = rd;
    endtask

    initial begin
        idle1();
        idle3();
        rst = 1;
        tick(); tick();
        rst = 0;
        check("rst_preMwk",  {31'd0, b1.preMwk}, 32'd0);
        check("rst_ppreMwk", {31'd0, b1.ppreMwk}, 32'd0);
        check("rst_ctrl",    {29'd0, b1.stall, b1.bubble, b1.flush}, 32'd0);

        // ALU op rd=5
        b1.exValid = 1; b1.exRegWr = 1; b1.exRegDst = 2'b00; b1.exrd = 5;
        b1.exAluOutput = 32'h1234; b1.excmp = 2'b10;
        tick();
        idle1();
        check("alu_preMwk", {31'd0, b1.preMwk}, 32'd1);
        check("alu_prerd",  {27'd0, b1.prerd}, 32'd5);
        check("alu_preAlu", b1.preAluOutput, 32'h1234);
        check("alu_precmp", {30'd0, b1.precmp}, 32'd2);
        tick();
        check("alu_ppreMwk", {31'd0, b1.ppreMwk}, 32'd1);
        check("alu_pprerd",  {27'd0, b1.pprerd}, 32'd5);
        check("alu_ppreAlu", b1.ppreAluOutput, 32'h1234);
        check("alu_pre_clr", {31'd0, b1.preMwk}, 32'd0);

        // Load rd=7, ID uses rs2=7
        b1.exValid = 1; b1.exRegWr = 1; b1.exRegDst = 2'b01; b1.exrd = 7;
        b1.idValid = 1; b1.idUsesRs1 = 1; b1.idrs1 = 3; b1.idUsesRs2 = 1; b1.idrs2 = 7;
        #1;
        check("lu_ctrl", {29'd0, b1.stall, b1.bubble, b1.flush}, 32'b110);
        tick();
        b1.exValid = 0; b1.exRegWr = 0; b1.exRegDst = 2'b00; b1.exrd = 0;
        b1.memDataOut = 32'hCAFE;
        #1;
        check("lu_release", {31'd0, b1.stall}, 32'd0);
        check("lu_preDst",  {30'd0, b1.preRegDst}, 32'd1);
        tick();
        b1.memDataOut = 0;
        check("lu_ppreData", b1.ppreDataOut, 32'hCAFE);
        check("lu_ppreDst",  {30'd0, b1.ppreRegDst}, 32'd1);
        check("lu_pprerd",   {27'd0, b1.pprerd}, 32'd7);
        check("lu_ppreMwk",  {31'd0, b1.ppreMwk}, 32'd1);
        idle1();

        // Load to x0 never stalls and never marks pre valid
        b1.exValid = 1; b1.exRegWr = 1; b1.exRegDst = 2'b01; b1.exrd = 0;
        b1.idValid = 1; b1.idUsesRs1 = 1; b1.idrs1 = 0;
        #1;
        check("x0_stall", {31'd0, b1.stall}, 32'd0);
        tick();
        check("x0_preMwk", {31'd0, b1.preMwk}, 32'd0);
        idle1();

        // Non-load producer and unused source register: no hazard
        b1.exValid = 1; b1.exRegWr = 1; b1.exRegDst = 2'b00; b1.exrd = 6;
        b1.idValid = 1; b1.idUsesRs1 = 1; b1.idrs1 = 6;
        #1;
        check("alu_dep_nostall", {31'd0, b1.stall}, 32'd0);
        b1.exRegDst = 2'b01; b1.idUsesRs1 = 0;
        #1;
        check("unused_src_nostall", {31'd0, b1.stall}, 32'd0);
        b1.idUsesRs1 = 1; b1.exValid = 0;
        #1;
        check("ex_bubble_nostall", {31'd0, b1.stall}, 32'd0);
        tick();
        idle1();

        // Both sources match: one stall cycle only
        b1.exValid = 1; b1.exRegWr = 1; b1.exRegDst = 2'b01; b1.exrd = 9;
        b1.idValid = 1; b1.idUsesRs1 = 1; b1.idrs1 = 9; b1.idUsesRs2 = 1; b1.idrs2 = 9;
        #1;
        check("dual_stall", {31'd0, b1.stall}, 32'd1);
        tick();
        b1.exValid = 0; b1.exRegWr = 0; b1.exRegDst = 2'b00; b1.exrd = 0;
        #1;
        check("dual_release", {31'd0, b1.stall}, 32'd0);
        tick();
        idle1();

        // Branch beats load-use hazard
        b1.exValid = 1; b1.exRegWr = 1; b1.exRegDst = 2'b01; b1.exrd = 3;
        b1.idValid = 1; b1.idUsesRs1 = 1; b1.idrs1 = 3; b1.exBranchTaken = 1;
        #1;
        check("br_ctrl", {29'd0, b1.stall, b1.bubble, b1.flush}, 32'b011);
        tick();
        idle1();
        #1;
        check("br_after", {29'd0, b1.stall, b1.bubble, b1.flush}, 32'b000);

        // Three-cycle stall
        load3(5'd4);
        #1;
        check("ls3_c0", {30'd0, b3.stall, b3.bubble}, 32'b11);
        tick();
        b3.exValid = 0; b3.exRegWr = 0; b3.exRegDst = 2'b00; b3.exrd = 0;
        b3.exBranchTaken = 1;
        #1;
        check("ls3_c1", {29'd0, b3.stall, b3.bubble, b3.flush}, 32'b110);
        tick();
        b3.exBranchTaken = 0;
        #1;
        check("ls3_c2", {30'd0, b3.stall, b3.bubble}, 32'b11);
        tick();
        check("ls3_c3", {30'd0, b3.stall, b3.bubble}, 32'b00);
        idle3();
        tick();

        // Reset during the second stall cycle aborts the stall
        load3(5'd4);
        #1;
        check("rs_c0", {31'd0, b3.stall}, 32'd1);
        tick();
        idle3();
        rst = 1;
        #1;
        check("rs_c1", {31'd0, b3.stall}, 32'd1);
        tick();
        rst = 0;
        #1;
        check("rs_ctrl",    {29'd0, b3.stall, b3.bubble, b3.flush}, 32'b000);
        check("rs_ppreMwk", {31'd0, b3.ppreMwk}, 32'd0);
        check("rs_preMwk",  {31'd0, b3.preMwk}, 32'd0);
        tick();
        check("rs_stay_run", {31'd0, b3.stall}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
`default_nettype wire
